// File: rtl/uart_pkg.sv
// Shared receiver types, frame constants and baud-timing helpers for uart_rx.
// The PARITY state is only present when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam int   CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    function automatic int calc_bit_period(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

    function automatic int calc_half_period(input int bit_period);
        return bit_period / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Reset value is a parameter so an idle-high line does not look like a start bit.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with
// mid-bit sampling, frame/parity error pulses and break detection.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUDRATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int BIT_PERIOD  = calc_bit_period(CLK_FREQ, BAUDRATE);
    localparam int HALF_PERIOD = calc_half_period(BIT_PERIOD);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    if (BIT_PERIOD < 4 || BIT_PERIOD > 65535) begin : g_bad_bit_period
        $error("uart_rx: CLK_FREQ/BAUDRATE must give a bit period of 4..65535 cycles");
    end

    logic rx_s;

    uart_sync2 #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .clk_i  (clk),
        .reset_i(reset),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    // IDLE wait start | START mid-start check | DATA 8 bits LSB first | PARITY even bit | STOP check | BREAK wait high
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             busy_q;
`ifdef UART_RX_PARITY_EN
    logic             parity_err_q;
    logic             par_bad_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_q       <= 8'h00;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
            par_bad_q    <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                    end
                end

                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= (rx_s != ^shift_q);
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
`endif
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Held-low stop bit: park in BREAK so the low line is not seen as a new start.
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_q <= par_bad_q;
`endif
                            state_q <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_BREAK: begin
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BIT_PERIOD=16; frames are built from
// bit lists and outcomes predicted from the frame rules (good stop/parity -> byte).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BP = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         vcnt    = 0;
    int         fecnt   = 0;
    int         pecnt   = 0;
    int         glitch  = 0;
    int         overlap = 0;
    logic [7:0] vq[$];
    logic [7:0] prev_data = 8'h00;

    uart_rx #(
        .CLK_FREQ(1600000),
        .BAUDRATE(100000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: records every valid byte, counts error pulses, flags data changing without valid.
    always @(negedge clk) begin
        if (reset) begin
            prev_data = 8'h00;
        end else begin
            if (valid) begin
                vcnt = vcnt + 1;
                vq.push_back(data);
            end else if (data !== prev_data) begin
                glitch = glitch + 1;
            end
            if (frame_err) fecnt = fecnt + 1;
            if (parity_err) pecnt = pecnt + 1;
            if (valid && (frame_err || parity_err)) overlap = overlap + 1;
            prev_data = data;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [FB-1:0] build_frame(input logic [7:0] b, input logic stop_bit);
        logic [FB-1:0] f;
        f      = '0;
        f[8:1] = b;
`ifdef UART_RX_PARITY_EN
        f[9]   = ^b;
`endif
        f[FB-1] = stop_bit;
        return f;
    endfunction

    task automatic send_frame(input logic [FB-1:0] f);
        for (int i = 0; i < FB; i++) begin
            rx = f[i];
            tick(BP);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", data); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single_byte;
        int v0, q0, fe0, pe0;
        v0 = vcnt; q0 = vq.size(); fe0 = fecnt; pe0 = pecnt;
        send_frame(build_frame(8'hA5, 1'b1));
        tick(4);
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_count: got %0d expected 1", vcnt - v0); end
        n_checks++; if (vq.size() <= q0 || vq[q0] !== 8'hA5) begin n_fail++; $display("FAIL a5_valid_data: got %h expected a5", (vq.size() > q0) ? vq[q0] : 8'hxx); end
        n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h expected a5", data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy: got %b expected 0", busy); end
        n_checks++; if (fecnt - fe0 !== 0 || pecnt - pe0 !== 0) begin n_fail++; $display("FAIL a5_errors: got fe=%0d pe=%0d expected 0 0", fecnt - fe0, pecnt - pe0); end
    endtask

    task automatic test_glitch;
        int v0, fe0;
        v0 = vcnt; fe0 = fecnt;
        rx = 1'b0;
        tick(4);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b expected 1", busy); end
        rx = 1'b1;
        tick(BP / 2 + 3);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_fall: got %b expected 0", busy); end
        n_checks++; if (vcnt - v0 !== 0 || fecnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_pulses: got valid=%0d fe=%0d expected 0 0", vcnt - v0, fecnt - fe0); end
        tick(10);
    endtask

    task automatic test_frame_err;
        int v0, fe0;
        logic [FB-1:0] f;
        v0 = vcnt; fe0 = fecnt;
        send_frame(build_frame(8'h11, 1'b1));
        tick(2);
        n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL fe_first_byte: got %h expected 11", data); end
        f = build_frame(8'h3C, 1'b0);
        for (int i = 0; i < FB - 1; i++) begin
            rx = f[i];
            tick(BP);
        end
        rx = 1'b0;
        tick(40);
        n_checks++; if (fecnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulse_count: got %0d expected 1", fecnt - fe0); end
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL fe_valid_count: got %0d expected 1", vcnt - v0); end
        n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL fe_data_kept: got %h expected 11", data); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fe_busy_in_break: got %b expected 1", busy); end
        rx = 1'b1;
        tick(4);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fe_busy_after_break: got %b expected 0", busy); end
        tick(8);
    endtask

    task automatic test_back_to_back;
        int v0, q0;
        v0 = vcnt; q0 = vq.size();
        send_frame(build_frame(8'h00, 1'b1));
        send_frame(build_frame(8'hFF, 1'b1));
        tick(4);
        n_checks++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", vcnt - v0); end
        n_checks++; if (vq.size() < q0 + 2 || vq[q0] !== 8'h00) begin n_fail++; $display("FAIL b2b_first: got size %0d expected byte 00", vq.size() - q0); end
        n_checks++; if (vq.size() < q0 + 2 || vq[q0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_second: got size %0d expected byte ff", vq.size() - q0); end
        n_checks++; if (data !== 8'hFF) begin n_fail++; $display("FAIL b2b_data: got %h expected ff", data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, pe0, fe0;
        logic [FB-1:0] f;
        v0 = vcnt; pe0 = pecnt; fe0 = fecnt;
        send_frame(build_frame(8'h07, 1'b1));
        tick(4);
        n_checks++; if (vcnt - v0 !== 1 || data !== 8'h07) begin n_fail++; $display("FAIL par_good: got valid=%0d data=%h expected 1 07", vcnt - v0, data); end
        f = build_frame(8'h07, 1'b1);
        f[9] = ~f[9];
        send_frame(f);
        f = build_frame(8'h06, 1'b1);
        f[9] = ~f[9];
        send_frame(f);
        tick(4);
        n_checks++; if (pecnt - pe0 !== 2) begin n_fail++; $display("FAIL par_err_count: got %0d expected 2", pecnt - pe0); end
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL par_no_valid: got %0d expected 1", vcnt - v0); end
        n_checks++; if (data !== 8'h07) begin n_fail++; $display("FAIL par_data_kept: got %h expected 07", data); end
        n_checks++; if (fecnt - fe0 !== 0) begin n_fail++; $display("FAIL par_no_fe: got %0d expected 0", fecnt - fe0); end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int v0, q0;
        logic [FB-1:0] f;
        f = build_frame(8'h5A, 1'b1);
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            tick(BP);
        end
        rx = f[5];
        tick(BP / 2);
        reset = 1'b1;
        tick(2);
        n_checks++; if (busy !== 1'b0 || data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_state: got busy=%b data=%h expected 0 00", busy, data); end
        rx = 1'b1;
        tick(1);
        reset = 1'b0;
        v0 = vcnt; q0 = vq.size();
        tick(20);
        send_frame(build_frame(8'h81, 1'b1));
        tick(4);
        n_checks++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 1", vcnt - v0); end
        n_checks++; if (vq.size() <= q0 || vq[q0] !== 8'h81) begin n_fail++; $display("FAIL rst_mid_byte: got size %0d expected byte 81", vq.size() - q0); end
        n_checks++; if (data !== 8'h81) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 81", data); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic [7:0] last_good;
        logic [7:0] b;
        logic [FB-1:0] f;
        bit stop_ok, par_flip;
        int v0, q0, fe0, pe0, exp_fe, exp_pe;
        v0 = vcnt; q0 = vq.size(); fe0 = fecnt; pe0 = pecnt;
        exp_fe = 0; exp_pe = 0;
        last_good = 8'h81;
        for (int n = 0; n < 24; n++) begin
            b        = 8'($urandom);
            stop_ok  = ($urandom_range(0, 4) != 0);
            par_flip = 1'b0;
            f = build_frame(b, stop_ok);
`ifdef UART_RX_PARITY_EN
            par_flip = ($urandom_range(0, 3) == 0);
            if (par_flip) f[9] = ~f[9];
`endif
            send_frame(f);
            if (!stop_ok) begin
                rx = 1'b0;
                tick($urandom_range(0, 30));
                rx = 1'b1;
                tick(1 + $urandom_range(0, 3));
            end else begin
                tick($urandom_range(0, 3));
            end
            if (stop_ok && !par_flip) begin
                exp_q.push_back(b);
                last_good = b;
            end
            if (!stop_ok) exp_fe++;
            if (par_flip) exp_pe++;
        end
        rx = 1'b1;
        tick(6);
        n_checks++; if (vcnt - v0 !== exp_q.size()) begin n_fail++; $display("FAIL rand_valid_count: got %0d expected %0d", vcnt - v0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (vq.size() <= q0 + i || vq[q0+i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_byte_%0d: got %h expected %h", i, (vq.size() > q0 + i) ? vq[q0+i] : 8'hxx, exp_q[i]);
            end
        end
        n_checks++; if (fecnt - fe0 !== exp_fe) begin n_fail++; $display("FAIL rand_fe_count: got %0d expected %0d", fecnt - fe0, exp_fe); end
        n_checks++; if (pecnt - pe0 !== exp_pe) begin n_fail++; $display("FAIL rand_pe_count: got %0d expected %0d", pecnt - pe0, exp_pe); end
        n_checks++; if (data !== last_good) begin n_fail++; $display("FAIL rand_last_data: got %h expected %h", data, last_good); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_pulse_hygiene;
        n_checks++; if (glitch !== 0) begin n_fail++; $display("FAIL data_change_without_valid: got %0d expected 0", glitch); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL valid_with_error: got %0d expected 0", overlap); end
`ifndef UART_RX_PARITY_EN
        n_checks++; if (pecnt !== 0) begin n_fail++; $display("FAIL parity_err_tied: got %0d expected 0", pecnt); end
`endif
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_random();
        test_pulse_hygiene();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
